// File: rtl/rvv_backend_rs_mpmp_if.sv
// Bundle of dispatch-side (push), execution-side (pop) and status signals for one
// multi-push / multi-pop reservation-station FIFO.
interface rvv_backend_rs_mpmp_if #(
    parameter int DWIDTH   = 32,
    parameter int NUM_PUSH = 2,
    parameter int NUM_POP  = 2,
    parameter int CW       = 4
);
    logic                         flush;
    logic [NUM_PUSH-1:0]          push;
    logic [NUM_PUSH*DWIDTH-1:0]   push_data;
    logic [NUM_POP-1:0]           pop;
    logic [NUM_POP*DWIDTH-1:0]    out_data;
    logic [NUM_POP-1:0]           out_valid;
    logic [CW-1:0]                count;
    logic [CW-1:0]                free_cnt;
    logic                         full;
    logic                         almost_full;
    logic                         half_full;
    logic                         empty;
    logic                         err;

    modport master (
        output flush, push, push_data, pop,
        input  out_data, out_valid, count, free_cnt, full, almost_full, half_full, empty, err
    );

    modport slave (
        input  flush, push, push_data, pop,
        output out_data, out_valid, count, free_cnt, full, almost_full, half_full, empty, err
    );
endinterface

// File: rtl/rvv_backend_rs_mpmp.sv
// Multi-push / multi-pop reservation-station FIFO: up to NUM_PUSH writes and NUM_POP
// oldest-first reads per cycle, with occupancy status, flush and a sticky error flag.
module rvv_backend_rs_mpmp #(
    parameter int DWIDTH     = 32,
    parameter int DEPTH      = 8,
    parameter int NUM_PUSH   = 2,
    parameter int NUM_POP    = 2,
    parameter int AFULL_LEFT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    rvv_backend_rs_mpmp_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              err_q, err_d;

    logic [CW-1:0]     free_w;
    logic [CW-1:0]     push_len, pop_len;
    logic [CW-1:0]     push_acc, pop_acc;
    logic              push_gap, pop_gap;
    logic              push_bad, pop_bad;

    assign free_w = CW'(DEPTH) - count_q;

    // A non-thermometer request counts only up to its first hole; anything above is flagged.
    always_comb begin
        // NOTE: every variable gets a default before the loops so no path leaves it unassigned (no latch).
        push_len = '0;
        push_gap = 1'b0;
        push_bad = 1'b0;
        for (int i = 0; i < NUM_PUSH; i++) begin
            if (!bus.push[i])  push_gap = 1'b1;
            else if (push_gap) push_bad = 1'b1;
            else               push_len = push_len + CW'(1);
        end
        pop_len = '0;
        pop_gap = 1'b0;
        pop_bad = 1'b0;
        for (int i = 0; i < NUM_POP; i++) begin
            if (!bus.pop[i])  pop_gap = 1'b1;
            else if (pop_gap) pop_bad = 1'b1;
            else              pop_len = pop_len + CW'(1);
        end
    end

    // Push space is judged against the pre-pop occupancy: a slot freed this cycle is not reused.
    assign push_acc = (push_len > free_w)  ? free_w  : push_len;
    assign pop_acc  = (pop_len  > count_q) ? count_q : pop_len;

    always_comb begin
        rd_ptr_d = rd_ptr_q + AW'(pop_acc);
        wr_ptr_d = wr_ptr_q + AW'(push_acc);
        count_d  = count_q + push_acc - pop_acc;
        err_d    = err_q | push_bad | pop_bad | (push_len > free_w) | (pop_len > count_q);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else if (bus.flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // NOTE: the storage array has no reset; out_valid qualifies every read slot.
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush) begin
            for (int i = 0; i < NUM_PUSH; i++) begin
                if (CW'(i) < push_acc)
                    mem_q[wr_ptr_q + AW'(i)] <= bus.push_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    always_comb begin
        bus.out_data  = '0;
        bus.out_valid = '0;
        for (int i = 0; i < NUM_POP; i++) begin
            bus.out_data[i*DWIDTH +: DWIDTH] = mem_q[rd_ptr_q + AW'(i)];
            bus.out_valid[i]                 = (count_q > CW'(i));
        end
    end

    assign bus.count       = count_q;
    assign bus.free_cnt    = free_w;
    assign bus.full        = (count_q == CW'(DEPTH));
    assign bus.almost_full = (free_w <= CW'(AFULL_LEFT));
    assign bus.half_full   = (count_q >= CW'(DEPTH / 2));
    assign bus.empty       = (count_q == '0);
    assign bus.err         = err_q;
endmodule

// File: tb/tb_rvv_backend_rs_mpmp.sv
// Self-checking bench for rvv_backend_rs_mpmp: directed vector table, hand sequences for
// wrap/underflow, then randomized traffic against a queue-based reference model.
module tb_rvv_backend_rs_mpmp;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int NP    = 2;
    localparam int NQ    = 2;
    localparam int AFL   = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rvv_backend_rs_mpmp_if #(.DWIDTH(DW), .NUM_PUSH(NP), .NUM_POP(NQ), .CW(CW)) bus ();

    rvv_backend_rs_mpmp #(
        .DWIDTH(DW), .DEPTH(DEPTH), .NUM_PUSH(NP), .NUM_POP(NQ), .AFULL_LEFT(AFL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the FIFO is just an ordered queue plus a sticky error bit.
    logic [DW-1:0] mq[$];
    bit            m_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit f, input logic [NP-1:0] pu,
                              input logic [NQ-1:0] po, input logic [NP*DW-1:0] pd);
        int used, free, npu, npo, lpu, lpo, apu, apo;
        if (r) begin
            mq.delete();
            m_err = 1'b0;
        end else if (f) begin
            mq.delete();
        end else begin
            used = mq.size();
            free = DEPTH - used;
            npu  = $countones(pu);
            npo  = $countones(po);
            lpu  = 0;
            lpo  = 0;
            for (int i = 0; i < NP; i++) if (pu[i] && lpu == i) lpu++;
            for (int i = 0; i < NQ; i++) if (po[i] && lpo == i) lpo++;
            if (npu > free || npo > used || npu != lpu || npo != lpo) m_err = 1'b1;
            apo = (lpo < used) ? lpo : used;
            apu = (lpu < free) ? lpu : free;
            repeat (apo) void'(mq.pop_front());
            for (int i = 0; i < apu; i++) mq.push_back(pd[i*DW +: DW]);
        end
    endtask

    task automatic compare(input string tag);
        int n;
        n = mq.size();
        check({tag, ".count"},       64'(bus.count),       64'(n));
        check({tag, ".free_cnt"},    64'(bus.free_cnt),    64'(DEPTH - n));
        check({tag, ".full"},        64'(bus.full),        64'(n == DEPTH));
        check({tag, ".empty"},       64'(bus.empty),       64'(n == 0));
        check({tag, ".half_full"},   64'(bus.half_full),   64'(n >= DEPTH / 2));
        check({tag, ".almost_full"}, 64'(bus.almost_full), 64'((DEPTH - n) <= AFL));
        check({tag, ".err"},         64'(bus.err),         64'(m_err));
        for (int i = 0; i < NQ; i++) begin
            check($sformatf("%s.out_valid%0d", tag, i), 64'(bus.out_valid[i]), 64'(n > i));
            if (i < n)
                check($sformatf("%s.out_data%0d", tag, i), 64'(bus.out_data[i*DW +: DW]), 64'(mq[i]));
        end
    endtask

    task automatic step(input bit r, input bit f, input logic [NP-1:0] pu, input logic [NQ-1:0] po,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1, input string tag);
        @(negedge clk);
        rst           = r;
        bus.flush     = f;
        bus.push      = pu;
        bus.pop       = po;
        bus.push_data = {d1, d0};
        @(posedge clk);
        model_step(r, f, pu, po, {d1, d0});
        #1;
        compare(tag);
    endtask

    typedef struct {
        bit            r;
        bit            f;
        logic [NP-1:0] pu;
        logic [NQ-1:0] po;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        int            cnt;
        bit            err;
        bit            chk0;
        logic [DW-1:0] o0;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bus.flush     = 1'b0;
        bus.push      = '0;
        bus.pop       = '0;
        bus.push_data = '0;

        //                r  f  push   pop    d0       d1       cnt err chk0 o0
        vecs.push_back('{1, 0, 2'b00, 2'b00, 16'h0,   16'h0,   0, 0, 0, 16'h0});
        vecs.push_back('{0, 0, 2'b00, 2'b00, 16'h0,   16'h0,   0, 0, 0, 16'h0});
        vecs.push_back('{0, 0, 2'b11, 2'b00, 16'hAAA1, 16'hBBB2, 2, 0, 1, 16'hAAA1});
        vecs.push_back('{0, 0, 2'b00, 2'b00, 16'h0,   16'h0,   2, 0, 1, 16'hAAA1});
        vecs.push_back('{0, 0, 2'b00, 2'b01, 16'h0,   16'h0,   1, 0, 1, 16'hBBB2});
        vecs.push_back('{0, 0, 2'b00, 2'b01, 16'h0,   16'h0,   0, 0, 0, 16'h0});
        vecs.push_back('{0, 0, 2'b11, 2'b00, 16'h0001, 16'h0002, 2, 0, 1, 16'h0001});
        vecs.push_back('{0, 0, 2'b11, 2'b00, 16'h0003, 16'h0004, 4, 0, 1, 16'h0001});
        vecs.push_back('{0, 0, 2'b11, 2'b00, 16'h0005, 16'h0006, 6, 0, 1, 16'h0001});
        vecs.push_back('{0, 0, 2'b11, 2'b00, 16'h0007, 16'h0008, 8, 0, 1, 16'h0001});
        vecs.push_back('{0, 0, 2'b01, 2'b00, 16'h0009, 16'h0000, 8, 1, 1, 16'h0001});
        vecs.push_back('{0, 0, 2'b11, 2'b11, 16'h000A, 16'h000B, 6, 1, 1, 16'h0003});
        vecs.push_back('{0, 1, 2'b11, 2'b00, 16'h000C, 16'h000D, 0, 1, 0, 16'h0});
        vecs.push_back('{0, 0, 2'b11, 2'b00, 16'h0E01, 16'h0E02, 2, 1, 1, 16'h0E01});
        vecs.push_back('{0, 0, 2'b01, 2'b00, 16'h0E03, 16'h0000, 3, 1, 1, 16'h0E01});
        vecs.push_back('{1, 0, 2'b11, 2'b11, 16'h0,   16'h0,   0, 0, 0, 16'h0});
        vecs.push_back('{0, 0, 2'b10, 2'b00, 16'h0F01, 16'h0F02, 0, 1, 0, 16'h0});
        vecs.push_back('{1, 0, 2'b00, 2'b00, 16'h0,   16'h0,   0, 0, 0, 16'h0});

        for (int v = 0; v < vecs.size(); v++) begin
            step(vecs[v].r, vecs[v].f, vecs[v].pu, vecs[v].po, vecs[v].d0, vecs[v].d1,
                 $sformatf("vec%0d", v));
            check($sformatf("vec%0d.tbl_count", v), 64'(bus.count), 64'(vecs[v].cnt));
            check($sformatf("vec%0d.tbl_err", v),   64'(bus.err),   64'(vecs[v].err));
            if (vecs[v].chk0)
                check($sformatf("vec%0d.tbl_out0", v), 64'(bus.out_data[DW-1:0]), 64'(vecs[v].o0));
        end

        // Wrap: advance both pointers to 7, then a double push straddles the 7 -> 0 boundary.
        for (int i = 0; i < 3; i++) step(0, 0, 2'b11, 2'b00, 16'(16'h100 + i), 16'(16'h200 + i), "wrap_fill");
        step(0, 0, 2'b01, 2'b00, 16'h0300, 16'h0, "wrap_fill1");
        for (int i = 0; i < 3; i++) step(0, 0, 2'b00, 2'b11, 16'h0, 16'h0, "wrap_drain");
        step(0, 0, 2'b00, 2'b01, 16'h0, 16'h0, "wrap_drain1");
        check("wrap.empty_before", 64'(bus.empty), 64'(1));
        step(0, 0, 2'b11, 2'b00, 16'hC0C0, 16'hD0D0, "wrap_push");
        check("wrap.C_first", 64'(bus.out_data[DW-1:0]),  64'(16'hC0C0));
        check("wrap.D_second", 64'(bus.out_data[2*DW-1:DW]), 64'(16'hD0D0));
        step(0, 0, 2'b00, 2'b01, 16'h0, 16'h0, "wrap_pop");
        check("wrap.D_after_pop", 64'(bus.out_data[DW-1:0]), 64'(16'hD0D0));
        check("wrap.err_clean", 64'(bus.err), 64'(0));

        // Underflow: two pops against a single entry.
        step(0, 0, 2'b00, 2'b11, 16'h0, 16'h0, "underflow");
        check("underflow.err", 64'(bus.err), 64'(1));

        // Flush with five entries and a same-cycle push, then reset with three entries.
        step(1, 0, 2'b00, 2'b00, 16'h0, 16'h0, "pre_flush_rst");
        step(0, 0, 2'b11, 2'b00, 16'h0501, 16'h0502, "f5a");
        step(0, 0, 2'b11, 2'b00, 16'h0503, 16'h0504, "f5b");
        step(0, 0, 2'b01, 2'b00, 16'h0505, 16'h0, "f5c");
        check("flush.count5", 64'(bus.count), 64'(5));
        step(0, 1, 2'b11, 2'b00, 16'h0506, 16'h0507, "flush");
        check("flush.empty", 64'(bus.empty), 64'(1));
        step(0, 0, 2'b11, 2'b00, 16'h0601, 16'h0602, "r3a");
        step(0, 0, 2'b01, 2'b00, 16'h0603, 16'h0, "r3b");
        step(0, 0, 2'b11, 2'b00, 16'h0604, 16'h0605, "r3_over");
        step(0, 0, 2'b00, 2'b11, 16'h0, 16'h0, "r3_pop");
        step(1, 0, 2'b11, 2'b11, 16'h0, 16'h0, "mid_rst");
        check("mid_rst.count", 64'(bus.count), 64'(0));
        check("mid_rst.err", 64'(bus.err), 64'(0));

        // Randomized traffic, mostly thermometer requests, with occasional flush and reset.
        for (int c = 0; c < 600; c++) begin
            logic [NP-1:0] pu;
            logic [NQ-1:0] po;
            bit            r, f;
            r  = ($urandom_range(0, 79) == 0);
            f  = ($urandom_range(0, 39) == 0);
            pu = ($urandom_range(0, 9) == 0) ? NP'($urandom) : NP'((1 << $urandom_range(0, NP)) - 1);
            po = ($urandom_range(0, 9) == 0) ? NQ'($urandom) : NQ'((1 << $urandom_range(0, NQ)) - 1);
            step(r, f, pu, po, DW'($urandom), DW'($urandom), $sformatf("rnd%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
